tracker_frame_sequencer: RTL and testbench
==========================================

// Module: tracker_frame_sequencer
// PURPOSE
//   Frame-level controller for the feature-tracker system datapath. Sequences one
//   IM_WIDTH x IM_HEIGHT frame of 8-bit pixels from a valid/ready source into the
//   system block, pulses its new_frame input, and drains its pipeline. It captures
//   match results into a one-entry valid/ready result buffer and reports per-frame
//   status. It sits between the pixel source and the system instance in main.
// PARAMETERS
//   IM_WIDTH      640   pixels per line; x counter counts 0..IM_WIDTH-1
//   IM_HEIGHT     480   lines per frame; y counter counts 0..IM_HEIGHT-1
//   DRAIN_CYCLES  64    cycles to hold in DRAIN after the last pixel; must be >= system latency (LE + margin)
// PORTS
//   clk            in   1   system clock
//   rst            in   1   synchronous active-high reset
//   start          in   1   request a frame; sampled only in IDLE
//   continuous     in   1   if 1 in DONE, go straight to SOF with no start needed
//   src_data       in   8   pixel from source
//   src_valid      in   1   src_data valid
//   src_ready      out  1   sequencer accepts a pixel this cycle
//   trk_data       out  8   to system data_in
//   trk_new_frame  out  1   to system new_frame
//   trk_match_flag in   1   from system match_flag
//   trk_xs/ys/xe/ye in  12  from system match box coordinates
//   trk_span       in   10  from system match_span
//   res_valid      out  1   result buffer full
//   res_ready      in   1   consumer takes the result
//   res_xs/ys/xe/ye out 12  buffered match box
//   res_span       out  10  buffered span
//   busy           out  1   state != IDLE
//   frame_done     out  1   one-cycle pulse at end of frame
//   match_count    out  16  matches seen this frame; saturates at 16'hFFFF
//   overflow       out  1   sticky per frame: a match was dropped
//   underrun       out  1   sticky per frame: src_valid was low during STREAM
// BEHAVIOUR
//   Reset: state=IDLE. All outputs are 0, including the res_* fields, the x/y
//     counters and all sticky flags. A reset mid-frame aborts immediately and drops
//     the buffered result.
//   FSM: IDLE -(start)-> SOF -> STREAM -(last pixel)-> DRAIN -(DRAIN_CYCLES)-> DONE;
//     DONE -> SOF if continuous=1, else DONE -> IDLE. DONE lasts exactly 1 cycle.
//     start is ignored outside IDLE.
//   SOF (1 cycle):
//     - clear match_count, overflow, underrun and x/y.
//     - trk_new_frame is registered and high exactly 1 cycle. That cycle immediately
//       precedes the first pixel on trk_data.
//   STREAM:
//     - src_ready=1. The system consumes one pixel every clock and cannot stall.
//     - Each cycle trk_data <= src_valid ? src_data : 8'h00, registered, so latency
//       is 1 cycle.
//     - Every STREAM cycle advances x; x wraps at IM_WIDTH-1 and then increments y.
//     - If src_valid=0, the slot is still consumed (zero pixel) and underrun is set.
//     - Cycle with x=IM_WIDTH-1, y=IM_HEIGHT-1 is the last; next state is DRAIN.
//     - Exactly IM_WIDTH*IM_HEIGHT cycles are spent in STREAM.
//   DRAIN: src_ready=0, trk_data=0, down-counter from DRAIN_CYCLES-1 to 0.
//   DONE: frame_done=1. match_count and flags hold until the next SOF.
//   Match capture (every state except IDLE) when trk_match_flag=1:
//     - match_count increments, saturating.
//     - If res_valid=0, or res_valid&res_ready in the same cycle: load res_* from
//       trk_*; res_valid=1 next cycle.
//     - Else: drop the match, set overflow, keep the old res_* unchanged.
//     - res_valid&res_ready with no new match: res_valid clears next cycle;
//       res_* hold their old values.
//   trk_match_flag in IDLE is ignored: no count, no load.
// TESTING
//   - IM_WIDTH=4, IM_HEIGHT=2, DRAIN_CYCLES=3, start pulse, src_valid=1 with data
//     1..8 -> trk_new_frame 1 cycle, trk_data=1..8 on consecutive cycles, busy for
//     1+8+3+1 cycles, one frame_done pulse, underrun=0.
//   - Same frame with src_valid=0 on pixel 5 -> trk_data=00 in that slot, underrun=1,
//     frame length unchanged.
//   - Matches on 2 consecutive cycles with res_ready=0 -> first match held, overflow=1,
//     match_count=2.
//   - res_valid=1, res_ready=1 and new match in the same cycle -> res_* take the new
//     match, res_valid stays 1, overflow=0.
//   - rst asserted mid-STREAM -> next cycle IDLE, all outputs 0, then a new start runs
//     a clean full frame.
//   - continuous=1 -> DONE goes directly to SOF. Counters/flags clear at the second
//     SOF. start held high while busy has no effect.

Source files
------------

// File: rtl/tracker_frame_sequencer_if.sv
// Pixel-source, tracker-system and result-buffer signals of the frame sequencer.
// master is the sequencer side; slave is the surrounding system/testbench side.
interface tracker_frame_sequencer_if;
    logic [7:0]  src_data;
    logic        src_valid;
    logic        src_ready;
    logic [7:0]  trk_data;
    logic        trk_new_frame;
    logic        trk_match_flag;
    logic [11:0] trk_xs;
    logic [11:0] trk_ys;
    logic [11:0] trk_xe;
    logic [11:0] trk_ye;
    logic [9:0]  trk_span;
    logic        res_valid;
    logic        res_ready;
    logic [11:0] res_xs;
    logic [11:0] res_ys;
    logic [11:0] res_xe;
    logic [11:0] res_ye;
    logic [9:0]  res_span;

    modport master (
        input  src_data, src_valid, trk_match_flag,
        input  trk_xs, trk_ys, trk_xe, trk_ye, trk_span, res_ready,
        output src_ready, trk_data, trk_new_frame, res_valid,
        output res_xs, res_ys, res_xe, res_ye, res_span
    );

    modport slave (
        output src_data, src_valid, trk_match_flag,
        output trk_xs, trk_ys, trk_xe, trk_ye, trk_span, res_ready,
        input  src_ready, trk_data, trk_new_frame, res_valid,
        input  res_xs, res_ys, res_xe, res_ye, res_span
    );
endinterface

// File: rtl/tracker_frame_sequencer.sv
// Frame-level controller: streams one frame of pixels into the tracker system,
// drains its pipeline, and buffers match results in a one-entry valid/ready slot.
module tracker_frame_sequencer #(
    parameter int IM_WIDTH     = 640,
    parameter int IM_HEIGHT    = 480,
    parameter int DRAIN_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        continuous,
    tracker_frame_sequencer_if.master   bus,
    output logic                        busy,
    output logic                        frame_done,
    output logic [15:0]                 match_count,
    output logic                        overflow,
    output logic                        underrun
);

    localparam int XW = (IM_WIDTH     > 1) ? $clog2(IM_WIDTH)     : 1;
    localparam int YW = (IM_HEIGHT    > 1) ? $clog2(IM_HEIGHT)    : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IM_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IM_HEIGHT - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [DW-1:0]   drain_cnt;
    logic            last_pix;

    logic [7:0]      pix_p1;
    logic            new_frame_p1;

    logic            capture;
    logic            res_take;
    logic            load;
    logic            drop;
    logic            res_valid_q;
    logic [11:0]     res_xs_q;
    logic [11:0]     res_ys_q;
    logic [11:0]     res_xe_q;
    logic [11:0]     res_ye_q;
    logic [9:0]      res_span_q;
    logic [15:0]     match_count_q;
    logic            overflow_q;
    logic            underrun_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign last_pix = (state == S_STREAM) && (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SOF;
            S_SOF:    state_nxt = S_STREAM;
            S_STREAM: if (last_pix) state_nxt = S_DRAIN;
            S_DRAIN:  if (drain_cnt == '0) state_nxt = S_DONE;
            S_DONE:   state_nxt = continuous ? S_SOF : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Raster position and drain countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == S_SOF) begin
                x <= '0;
                y <= '0;
            end else if (state == S_STREAM) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            if (last_pix)
                drain_cnt <= D_LAST;
            else if (state == S_DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // ---- stage p1: registered pixel and frame marker towards the tracker ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_p1       <= '0;
            new_frame_p1 <= 1'b0;
        end else begin
            pix_p1       <= (state == S_STREAM && bus.src_valid) ? bus.src_data : 8'h00;
            new_frame_p1 <= (state == S_SOF);
        end
    end

    // A consumer handshake frees the slot in the same cycle a new match arrives.
    assign capture  = (state != S_IDLE) && bus.trk_match_flag;
    assign res_take = res_valid_q && bus.res_ready;
    assign load     = capture && (!res_valid_q || res_take);
    assign drop     = capture && res_valid_q && !bus.res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q   <= 1'b0;
            res_xs_q      <= '0;
            res_ys_q      <= '0;
            res_xe_q      <= '0;
            res_ye_q      <= '0;
            res_span_q    <= '0;
            match_count_q <= '0;
            overflow_q    <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            if (load) begin
                res_xs_q   <= bus.trk_xs;
                res_ys_q   <= bus.trk_ys;
                res_xe_q   <= bus.trk_xe;
                res_ye_q   <= bus.trk_ye;
                res_span_q <= bus.trk_span;
            end
            if (load)          res_valid_q <= 1'b1;
            else if (res_take) res_valid_q <= 1'b0;

            // SOF restarts the per-frame statistics but still honours a match in that cycle
            if (state == S_SOF) begin
                match_count_q <= capture ? 16'd1 : 16'd0;
                overflow_q    <= drop;
                underrun_q    <= 1'b0;
            end else begin
                if (capture) match_count_q <= sat_inc(match_count_q);
                if (drop)    overflow_q    <= 1'b1;
                if (state == S_STREAM && !bus.src_valid) underrun_q <= 1'b1;
            end
        end
    end

    assign bus.src_ready     = (state == S_STREAM);
    assign bus.trk_data      = pix_p1;
    assign bus.trk_new_frame = new_frame_p1;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_xs        = res_xs_q;
    assign bus.res_ys        = res_ys_q;
    assign bus.res_xe        = res_xe_q;
    assign bus.res_ye        = res_ye_q;
    assign bus.res_span      = res_span_q;

    assign busy        = (state != S_IDLE);
    assign frame_done  = (state == S_DONE);
    assign match_count = match_count_q;
    assign overflow    = overflow_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_tracker_frame_sequencer.sv
// Directed bench for tracker_frame_sequencer on a 4x2 frame with a 3-cycle drain.
module tb_tracker_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        continuous;
    logic        busy;
    logic        frame_done;
    logic [15:0] match_count;
    logic        overflow;
    logic        underrun;

    int n_cmp = 0;
    int n_err = 0;

    tracker_frame_sequencer_if bus();

    tracker_frame_sequencer #(
        .IM_WIDTH    (4),
        .IM_HEIGHT   (2),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .bus        (bus.master),
        .busy       (busy),
        .frame_done (frame_done),
        .match_count(match_count),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int          f_busy;
    int          f_done;
    int          f_nf;
    logic [7:0]  got [8];
    logic        h_busy [32];
    logic        h_fd   [32];
    logic        h_nf   [32];
    logic        h_un   [32];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_match(input logic flag, input logic [11:0] base, input logic [9:0] span);
        bus.trk_match_flag = flag;
        bus.trk_xs   = base;
        bus.trk_ys   = base + 12'd1;
        bus.trk_xe   = base + 12'd2;
        bus.trk_ye   = base + 12'd3;
        bus.trk_span = span;
    endtask

    // Pulses start, feeds pixels 1..8 (gap = 1-based pixel sent with src_valid=0),
    // and records busy length, frame_done pulses, new_frame cycles and trk_data.
    task automatic run_frame(input int gap);
        int k;
        int cap;
        k = 0; cap = 0; f_busy = 0; f_done = 0; f_nf = 0;
        for (int i = 0; i < 8; i++) got[i] = 8'hxx;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (busy) f_busy++;
            if (frame_done) f_done++;
            if (bus.trk_new_frame) begin
                f_nf++;
                cap = 1;
            end else if (cap >= 1 && cap <= 8) begin
                got[cap-1] = bus.trk_data;
                cap++;
            end
            start = (cyc == 0);
            if (bus.src_ready) begin
                bus.src_data  = 8'(k + 1);
                bus.src_valid = (k + 1 != gap);
                k++;
            end else begin
                bus.src_data  = 8'h00;
                bus.src_valid = 1'b0;
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $error("FAIL wait_idle: observed busy=1 expected busy=0 within 40 cycles");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0;
        bus.src_data = 8'h00; bus.src_valid = 1'b0; bus.res_ready = 1'b0;
        set_match(1'b0, 12'h000, 10'h000);
        step(); step();
        rst = 1'b0;

        chk("rst_busy",      busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_src_ready", bus.src_ready, 0);
        chk("rst_trk_data",  bus.trk_data, 0);
        chk("rst_new_frame", bus.trk_new_frame, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_xs",    bus.res_xs, 0);
        chk("rst_count",     match_count, 0);
        chk("rst_flags",     {overflow, underrun}, 0);

        // Clean frame, pixels 1..8
        run_frame(0);
        chk("f1_busy_len", f_busy, 13);
        chk("f1_done",     f_done, 1);
        chk("f1_new_frame", f_nf, 1);
        for (int i = 0; i < 8; i++) chk($sformatf("f1_pix%0d", i + 1), got[i], i + 1);
        chk("f1_underrun", underrun, 0);
        chk("f1_idle",     busy, 0);

        // Pixel 5 not valid: zero slot, underrun, same length
        run_frame(5);
        chk("f2_busy_len", f_busy, 13);
        chk("f2_done",     f_done, 1);
        chk("f2_pix4",     got[3], 8'h04);
        chk("f2_pix5",     got[4], 8'h00);
        chk("f2_pix6",     got[5], 8'h06);
        chk("f2_underrun", underrun, 1);

        // Two back-to-back matches with no consumer: second is dropped
        bus.src_valid = 1'b1; bus.src_data = 8'h11;
        start = 1'b1; step(); start = 1'b0;
        step();
        chk("ov_src_ready", bus.src_ready, 1);
        set_match(1'b1, 12'h100, 10'h0AA);
        step();
        chk("ov_first_valid", bus.res_valid, 1);
        chk("ov_first_xs",    bus.res_xs, 12'h100);
        chk("ov_first_count", match_count, 1);
        set_match(1'b1, 12'h200, 10'h0BB);
        step();
        set_match(1'b0, 12'h000, 10'h000);
        chk("ov_valid",    bus.res_valid, 1);
        chk("ov_xs_held",  bus.res_xs, 12'h100);
        chk("ov_ye_held",  bus.res_ye, 12'h103);
        chk("ov_span",     bus.res_span, 10'h0AA);
        chk("ov_overflow", overflow, 1);
        chk("ov_count",    match_count, 2);
        wait_idle();
        chk("ov_hold_count", match_count, 2);
        chk("ov_hold_flag",  overflow, 1);

        // Consumer drains the slot in IDLE; fields hold
        bus.res_ready = 1'b1; step(); bus.res_ready = 1'b0;
        chk("take_valid",  bus.res_valid, 0);
        chk("take_xs_hold", bus.res_xs, 12'h100);

        // Matches in IDLE are ignored
        set_match(1'b1, 12'h300, 10'h0CC); step(); set_match(1'b0, 12'h000, 10'h000);
        chk("idle_count", match_count, 2);
        chk("idle_valid", bus.res_valid, 0);

        // Simultaneous take and new match replaces the entry without overflow
        start = 1'b1; step(); start = 1'b0;
        step();
        set_match(1'b1, 12'h400, 10'h0DD);
        step();
        chk("sw_first_xs", bus.res_xs, 12'h400);
        chk("sw_count_sof", match_count, 1);
        bus.res_ready = 1'b1;
        set_match(1'b1, 12'h500, 10'h0EE);
        step();
        set_match(1'b0, 12'h000, 10'h000);
        chk("sw_valid",    bus.res_valid, 1);
        chk("sw_xs",       bus.res_xs, 12'h500);
        chk("sw_xe",       bus.res_xe, 12'h502);
        chk("sw_span",     bus.res_span, 10'h0EE);
        chk("sw_overflow", overflow, 0);
        chk("sw_count",    match_count, 2);
        step();
        bus.res_ready = 1'b0;
        chk("sw_drained",  bus.res_valid, 0);
        wait_idle();

        // Reset mid-STREAM aborts the frame and drops the buffered result
        start = 1'b1; step(); start = 1'b0;
        step();
        bus.src_valid = 1'b0;
        set_match(1'b1, 12'h600, 10'h011);
        step();
        set_match(1'b0, 12'h000, 10'h000);
        bus.src_valid = 1'b1;
        chk("pre_rst_valid",    bus.res_valid, 1);
        chk("pre_rst_underrun", underrun, 1);
        rst = 1'b1; step(); rst = 1'b0;
        bus.src_valid = 1'b0;
        chk("mid_rst_busy",     busy, 0);
        chk("mid_rst_trk_data", bus.trk_data, 0);
        chk("mid_rst_res",      {bus.res_valid, bus.res_xs, bus.res_span}, 0);
        chk("mid_rst_count",    match_count, 0);
        chk("mid_rst_flags",    {overflow, underrun}, 0);
        run_frame(0);
        chk("post_rst_len",  f_busy, 13);
        chk("post_rst_done", f_done, 1);
        chk("post_rst_pix1", got[0], 8'h01);
        chk("post_rst_pix8", got[7], 8'h08);
        chk("post_rst_underrun", underrun, 0);

        // Continuous mode with start held high throughout
        begin
            int k;
            k = 0;
            continuous = 1'b1;
            for (int cyc = 0; cyc < 28; cyc++) begin
                h_busy[cyc] = busy;
                h_fd[cyc]   = frame_done;
                h_nf[cyc]   = bus.trk_new_frame;
                h_un[cyc]   = underrun;
                start = (cyc < 26);
                if (cyc == 20) continuous = 1'b0;
                if (bus.src_ready) begin
                    bus.src_data  = 8'(k + 1);
                    bus.src_valid = (k != 4);
                    k++;
                end else begin
                    bus.src_data  = 8'h00;
                    bus.src_valid = 1'b0;
                end
                step();
            end
        end
        start = 1'b0;
        chk("cont_nf1",        h_nf[2], 1);
        chk("cont_done1",      h_fd[13], 1);
        chk("cont_underrun1",  h_un[13], 1);
        chk("cont_sof2_busy",  h_busy[14], 1);
        chk("cont_sof2_fd",    h_fd[14], 0);
        chk("cont_nf2",        h_nf[15], 1);
        chk("cont_clear2",     h_un[15], 0);
        chk("cont_busy_mid",   h_busy[20], 1);
        chk("cont_done2",      h_fd[26], 1);
        chk("cont_idle",       h_busy[27], 0);
        chk("cont_no_restart", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
